// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encodings
// and default bus widths.
package instr_fetch_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: requests the word at pc_in from instruction
// memory, hands it to decode with valid/ready, then strobes the PC block to
// advance. A flush (redirect) discards whatever fetch is in progress; a
// response that is still owed by memory is drained before refetching.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_increment,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    fetch_state_t state;
    fetch_state_t state_next;

    // State register, cleared to IDLE by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush takes priority over every other event. A request
    // acked together with a flush counts as never issued, so REQ refetches
    // directly instead of draining.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    state_next = S_REQ;
                end else if (mem_ack) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_next = mem_rvalid ? S_REQ : S_DRAIN;
                end else if (mem_rvalid) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush || instr_ready) begin
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs come straight from the registered state; only the
    // increment strobe looks at the live accept condition.
    assign mem_req      = (state == S_REQ);
    assign instr_valid  = (state == S_HOLD);
    assign pc_increment = instr_valid && instr_ready && !flush;
    assign mem_addr     = mem_req ? pc_in : '0;

    // Capture the fetch address on ack and the instruction word on rvalid;
    // both stay frozen while decode stalls in HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_pc <= '0;
            instr    <= '0;
        end else begin
            if ((state == S_REQ) && mem_ack && !flush) begin
                instr_pc <= pc_in;
            end
            if ((state == S_WAIT) && mem_rvalid && !flush) begin
                instr <= mem_rdata;
            end
        end
    end

endmodule
